// File: rtl/tff_counter_pkg.sv
// Shared definitions for the toggle-flip-flop mode counter: mode encodings
// and the per-mode terminal-state helper.
package tff_counter_pkg;

    typedef enum logic [1:0] {
        MODE_UP      = 2'b00,
        MODE_DOWN    = 2'b01,
        MODE_JOHNSON = 2'b10,
        MODE_RING    = 2'b11
    } mode_e;

    // Terminal value of the sequence for a given mode, zero-extended to 32 bits.
    function automatic logic [31:0] terminal_value(
        input logic [1:0]      mode,
        input int unsigned     width,
        input longint unsigned modulus
    );
        logic [31:0] term;
        case (mode)
            MODE_UP:   term = 32'(modulus - 64'd1);
            MODE_DOWN: term = 32'd0;
            default:   term = 32'd1 << (width - 32'd1);
        endcase
        return term;
    endfunction

endpackage

// File: rtl/t_ff_bank.sv
// Bank of WIDTH toggle flip-flops updating on the falling clock edge;
// each bit inverts when its toggle input is high.
module t_ff_bank #(
    parameter int WIDTH = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] t,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] q_q;

    // Toggle storage: async clear, otherwise flip the selected bits.
    always_ff @(negedge clock or posedge reset) begin
        if (reset) begin
            q_q <= {WIDTH{1'b0}};
        end else begin
            q_q <= q_q ^ t;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/tff_mode_counter.sv
// Multi-mode counter (up / down / Johnson / ring) with parallel load,
// terminal-count flag and wrap pulse, built on a toggle flip-flop bank.
module tff_mode_counter
    import tff_counter_pkg::*;
#(
    parameter int              WIDTH   = 4,
    parameter longint unsigned MODULUS = 64'd1 << WIDTH
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic [1:0]       mode,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             wrap
);

    localparam logic [WIDTH-1:0] ZERO   = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] ONE    = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH:0]   MOD_W  = (WIDTH+1)'(MODULUS);
    localparam logic [WIDTH:0]   MOD_M1 = MOD_W - {{WIDTH{1'b0}}, 1'b1};

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] next_d;
    logic [WIDTH-1:0] t_d;
    logic [31:0]      term_d;
    logic             tc_d;
    logic             wrap_d;
    logic             wrap_q;

    // Next-state per mode; out-of-range binary values are folded back into range.
    always_comb begin
        next_d = count_q;
        case (mode)
            MODE_UP: begin
                if ({1'b0, count_q} >= MOD_M1) begin
                    next_d = ZERO;
                end else begin
                    next_d = count_q + ONE;
                end
            end
            MODE_DOWN: begin
                if ((count_q == ZERO) || ({1'b0, count_q} >= MOD_W)) begin
                    next_d = MOD_M1[WIDTH-1:0];
                end else begin
                    next_d = count_q - ONE;
                end
            end
            MODE_JOHNSON: begin
                next_d = {count_q[WIDTH-2:0], ~count_q[WIDTH-1]};
            end
            MODE_RING: begin
                if (count_q == ZERO) begin
                    next_d = ONE;
                end else begin
                    next_d = {count_q[WIDTH-2:0], count_q[WIDTH-1]};
                end
            end
            default: begin
                next_d = count_q;
            end
        endcase
    end

    // Toggle vector, terminal-count flag and wrap next-state.
    always_comb begin
        term_d = terminal_value(mode, 32'(WIDTH), MODULUS);
        tc_d   = en & ~load & (32'(count_q) == term_d);
        wrap_d = tc_d;
        if (load) begin
            t_d = count_q ^ load_val;
        end else if (en) begin
            t_d = count_q ^ next_d;
        end else begin
            t_d = ZERO;
        end
    end

    t_ff_bank #(
        .WIDTH (WIDTH)
    ) u_bank (
        .clock (clock),
        .reset (reset),
        .t     (t_d),
        .q     (count_q)
    );

    // Wrap pulse register: high for one period after leaving the terminal state.
    always_ff @(negedge clock or posedge reset) begin
        if (reset) begin
            wrap_q <= 1'b0;
        end else begin
            wrap_q <= wrap_d;
        end
    end

    assign count = count_q;
    assign tc    = tc_d;
    assign wrap  = wrap_q;

endmodule

// File: tb/tb_tff_mode_counter.sv
// Scoreboard bench for tff_mode_counter (WIDTH=4, MODULUS=10): a driver
// pushes reference-model expectations, a monitor pops and compares.
module tb_tff_mode_counter;

    typedef struct {
        int tc;
        int cnt;
        int wrap;
    } exp_t;

    logic       clock    = 1'b0;
    logic       reset    = 1'b0;
    logic       en       = 1'b0;
    logic       load     = 1'b0;
    logic [3:0] load_val = 4'd0;
    logic [1:0] mode     = 2'd0;
    logic [3:0] count;
    logic       tc;
    logic       wrap;

    int   errors = 0;
    int   checks = 0;
    int   m_cnt  = 0;
    exp_t sb[$];

    tff_mode_counter #(
        .WIDTH   (4),
        .MODULUS (64'd10)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .en       (en),
        .load     (load),
        .load_val (load_val),
        .mode     (mode),
        .count    (count),
        .tc       (tc),
        .wrap     (wrap)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference sequence rules, modulus 10 and 4-bit state.
    function automatic int ref_next(input int c, input int md);
        case (md)
            0:       return (c >= 9) ? 0 : c + 1;
            1:       return (c == 0 || c >= 10) ? 9 : c - 1;
            2:       return ((c * 2) % 16) + (((c / 8) % 2) == 1 ? 0 : 1);
            default: return (c == 0) ? 1 : ((c * 2) % 16) + ((c / 8) % 2);
        endcase
    endfunction

    function automatic int ref_term(input int md);
        case (md)
            0:       return 9;
            1:       return 0;
            default: return 8;
        endcase
    endfunction

    // One clock period of stimulus; reset cycles are checked directly.
    task automatic cyc(input bit r, input bit e, input bit l, input int lv, input int md);
        exp_t x;
        int   tcx;
        @(posedge clock);
        #1;
        reset    = r;
        en       = e;
        load     = l;
        load_val = 4'(lv);
        mode     = 2'(md);
        if (r) begin
            #1;
            chk("async_reset_count", int'(count), 0);
            chk("async_reset_wrap", int'(wrap), 0);
            m_cnt = 0;
        end else begin
            tcx = (e && !l && m_cnt == ref_term(md)) ? 1 : 0;
            if (l) m_cnt = lv;
            else if (e) m_cnt = ref_next(m_cnt, md);
            x.tc   = tcx;
            x.cnt  = m_cnt;
            x.wrap = tcx;
            sb.push_back(x);
        end
    endtask

    // Monitor: tc before the falling edge, count/wrap just after it.
    initial begin
        exp_t x;
        forever begin
            @(posedge clock);
            #3;
            if (sb.size() > 0) begin
                x = sb[0];
                chk("tc", int'(tc), x.tc);
                @(negedge clock);
                #1;
                x = sb.pop_front();
                chk("count", int'(count), x.cnt);
                chk("wrap", int'(wrap), x.wrap);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish before 200000");
        $fatal(1);
    end

    initial begin
        // reset state
        cyc(1'b1, 1'b0, 1'b0, 0, 0);
        // up to 6, reset between edges, resume from 0
        for (int i = 0; i < 6; i++) cyc(1'b0, 1'b1, 1'b0, 0, 0);
        cyc(1'b1, 1'b1, 1'b0, 0, 0);
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, 1'b0, 0, 0);
        cyc(1'b1, 1'b0, 1'b0, 0, 0);
        // full up cycle with wrap, then a hold
        for (int i = 0; i < 10; i++) cyc(1'b0, 1'b1, 1'b0, 0, 0);
        // reset right after the wrap pulse
        cyc(1'b1, 1'b0, 1'b0, 0, 0);
        cyc(1'b0, 1'b0, 1'b0, 0, 0);
        // load 3 then count down across 0
        cyc(1'b0, 1'b0, 1'b1, 3, 1);
        for (int i = 0; i < 6; i++) cyc(1'b0, 1'b1, 1'b0, 0, 1);
        // Johnson from 0
        cyc(1'b1, 1'b0, 1'b0, 0, 0);
        for (int i = 0; i < 9; i++) cyc(1'b0, 1'b1, 1'b0, 0, 2);
        cyc(1'b0, 1'b0, 1'b0, 0, 2);
        // ring from 0, switch to up at 8
        cyc(1'b1, 1'b0, 1'b0, 0, 0);
        for (int i = 0; i < 4; i++) cyc(1'b0, 1'b1, 1'b0, 0, 3);
        cyc(1'b0, 1'b1, 1'b0, 0, 0);
        for (int i = 0; i < 6; i++) cyc(1'b0, 1'b1, 1'b0, 0, 3);
        // out-of-range load with en high, then step and hold
        cyc(1'b0, 1'b1, 1'b1, 12, 0);
        cyc(1'b0, 1'b1, 1'b0, 0, 0);
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 1'b0, 0, 0);
        // out-of-range value in down mode
        cyc(1'b0, 1'b0, 1'b1, 14, 1);
        cyc(1'b0, 1'b1, 1'b0, 0, 1);
        // randomized traffic
        for (int i = 0; i < 500; i++) begin
            cyc(($urandom_range(99) < 2), ($urandom_range(99) < 75),
                ($urandom_range(99) < 10), int'($urandom_range(15)),
                int'($urandom_range(3)));
        end
        cyc(1'b0, 1'b0, 1'b0, 0, 0);
        repeat (3) @(posedge clock);
        chk("scoreboard_drained", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
